// File: rtl/add_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding, counter sizing
// and parameter legality.
package add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Digit counter width; a single-digit configuration still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple chain of full-adder cells; also exposes the carry into the
// top bit so the caller can form signed overflow.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, LSB digit first, with a
// valid/ready handshake on both operand and result sides.
module serial_add_sub
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);
  localparam int unsigned IW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(NDIG - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $fatal(1, "serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [IW-1:0]    lsb;
  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_co, dig_cmsb;

  assign lsb   = IW'(int'(cnt_q) * DIGIT);
  assign dig_a = a_q[lsb +: DIGIT];
  assign dig_b = b_q[lsb +: DIGIT];

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .co   (dig_co),
    .c_msb(dig_cmsb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      // Abort keeps the last result visible but discards all in-flight state.
      state_d     = StIdle;
      out_valid_d = 1'b0;
      carry_d     = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = cin;
            cnt_d   = '0;
            sum_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          sum_d[lsb +: DIGIT] = dig_s;
          carry_d             = dig_co;
          if (cnt_q == LastCnt) begin
            cout_d      = dig_co;
            ovf_d       = dig_co ^ dig_cmsb;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Registered copy of "next state is IDLE" so in_ready stays low throughout reset.
    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
